// File: rtl/sgbm_pkg.sv
// Constants shared by the SGBM back end (cost_aggr_packer, disparity_calc)
// and the ping-pong output bank state encoding.
package sgbm_pkg;

    localparam int NDISP = 54;
    localparam int CW    = 16;
    localparam int IMG_W = 640;
    localparam int IMG_H = 480;
    localparam int RCW   = 10;

    typedef enum logic [1:0] {
        BANK_EMPTY = 2'd0,
        BANK_ONE   = 2'd1,
        BANK_TWO   = 2'd2
    } bank_state_e;

endpackage

// File: rtl/cost_bank.sv
// One ping-pong bank: NDISP cost slots, the pixel's row/col tag and a full flag.
module cost_bank #(
    parameter int NDISP = sgbm_pkg::NDISP,
    parameter int CW    = sgbm_pkg::CW,
    parameter int RCW   = sgbm_pkg::RCW,
    parameter int IW    = $clog2(NDISP)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [IW-1:0]       wr_idx,
    input  logic [CW-1:0]       wr_data,
    input  logic                set_full,
    input  logic                clr_full,
    input  logic [RCW-1:0]      tag_row,
    input  logic [RCW-1:0]      tag_col,
    output logic [NDISP*CW-1:0] slots,
    output logic [RCW-1:0]      row,
    output logic [RCW-1:0]      col,
    output logic                full
);

    import sgbm_pkg::*;

    logic [NDISP-1:0][CW-1:0] mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // The tag is latched together with the last slot so it always matches the data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row  <= '0;
            col  <= '0;
            full <= 1'b0;
        end else begin
            if (set_full) begin
                row  <= tag_row;
                col  <= tag_col;
                full <= 1'b1;
            end else if (clr_full) begin
                full <= 1'b0;
            end
        end
    end

    assign slots = mem;

endmodule

// File: rtl/cost_aggr_packer.sv
// Serial-to-parallel cost packer: gathers NDISP cost beats per pixel into a
// wide bus for disparity_calc, with raster tags and two ping-pong banks.
module cost_aggr_packer #(
    parameter int NDISP = sgbm_pkg::NDISP,
    parameter int CW    = sgbm_pkg::CW,
    parameter int IMG_W = sgbm_pkg::IMG_W,
    parameter int IMG_H = sgbm_pkg::IMG_H,
    parameter int RCW   = sgbm_pkg::RCW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [CW-1:0]       s_cost,
    input  logic                s_sof,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [NDISP*CW-1:0] cost_aggr,
    output logic [RCW-1:0]      row_out,
    output logic [RCW-1:0]      col_out,
    output logic                sof_err
);

    import sgbm_pkg::*;

    localparam int IW = $clog2(NDISP);

    bank_state_e    state, state_nxt;
    logic [IW-1:0]  d_idx;
    logic [RCW-1:0] row_cnt, col_cnt;
    logic           fill_ptr, rd_ptr;

    logic           accept, restart, last_beat, handshake;
    logic [IW-1:0]  wr_slot;
    logic [RCW-1:0] pix_row, pix_col;

    logic [1:0]          bank_wr, bank_set, bank_clr, bank_full;
    logic [NDISP*CW-1:0] bank_slots [2];
    logic [RCW-1:0]      bank_row   [2];
    logic [RCW-1:0]      bank_col   [2];

    assign s_ready   = (state != BANK_TWO) && !rst;
    assign m_valid   = (state != BANK_EMPTY);
    assign accept    = s_valid && s_ready;
    assign handshake = m_valid && m_ready;

    // A start-of-frame beat always opens a fresh pixel at (0,0), dropping any partial one.
    assign restart   = accept && s_sof;
    assign wr_slot   = restart ? '0 : d_idx;
    assign last_beat = accept && (wr_slot == IW'(NDISP - 1));
    assign pix_row   = restart ? '0 : row_cnt;
    assign pix_col   = restart ? '0 : col_cnt;

    always_comb begin
        bank_wr           = '0;
        bank_set          = '0;
        bank_clr          = '0;
        bank_wr[fill_ptr] = accept && !bank_full[fill_ptr];
        bank_set[fill_ptr] = accept && !bank_full[fill_ptr] && last_beat;
        bank_clr[rd_ptr]  = handshake;
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        cost_bank #(
            .NDISP (NDISP),
            .CW    (CW),
            .RCW   (RCW),
            .IW    (IW)
        ) u_bank (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (bank_wr[b]),
            .wr_idx   (wr_slot),
            .wr_data  (s_cost),
            .set_full (bank_set[b]),
            .clr_full (bank_clr[b]),
            .tag_row  (pix_row),
            .tag_col  (pix_col),
            .slots    (bank_slots[b]),
            .row      (bank_row[b]),
            .col      (bank_col[b]),
            .full     (bank_full[b])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_idx    <= '0;
            row_cnt  <= '0;
            col_cnt  <= '0;
            fill_ptr <= 1'b0;
            rd_ptr   <= 1'b0;
            sof_err  <= 1'b0;
        end else begin
            if (accept) begin
                d_idx <= last_beat ? '0 : wr_slot + IW'(1);
                if (last_beat) begin
                    if (pix_col == RCW'(IMG_W - 1)) begin
                        col_cnt <= '0;
                        row_cnt <= (pix_row == RCW'(IMG_H - 1)) ? '0 : pix_row + RCW'(1);
                    end else begin
                        col_cnt <= pix_col + RCW'(1);
                        row_cnt <= pix_row;
                    end
                end else if (restart) begin
                    row_cnt <= '0;
                    col_cnt <= '0;
                end
                if (restart && (d_idx != '0)) begin
                    sof_err <= 1'b1;
                end
            end
            if (last_beat) begin
                fill_ptr <= ~fill_ptr;
            end
            if (handshake) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BANK_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Occupancy count of the two banks; a fill and a drain in one cycle cancel out.
    always_comb begin
        state_nxt = state;
        case (state)
            BANK_EMPTY: if (last_beat) state_nxt = BANK_ONE;
            BANK_ONE: begin
                if (last_beat && !handshake) begin
                    state_nxt = BANK_TWO;
                end else if (!last_beat && handshake) begin
                    state_nxt = BANK_EMPTY;
                end
            end
            BANK_TWO:   if (handshake) state_nxt = BANK_ONE;
            default:    state_nxt = BANK_EMPTY;
        endcase
    end

    assign cost_aggr = bank_slots[rd_ptr];
    assign row_out   = bank_row[rd_ptr];
    assign col_out   = bank_col[rd_ptr];

endmodule

// File: tb/tb_cost_aggr_packer.sv
// Self-checking bench for cost_aggr_packer: scoreboard of expected pixels plus
// a table of single-pixel vectors and hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_cost_aggr_packer;

    localparam int NDISP = 54;
    localparam int CW    = 16;
    localparam int IMG_W = 8;
    localparam int IMG_H = 2;
    localparam int RCW   = 10;
    localparam int DW    = NDISP * CW;

    logic          clk;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [CW-1:0] s_cost;
    logic          s_sof;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] cost_aggr;
    logic [RCW-1:0] row_out;
    logic [RCW-1:0] col_out;
    logic          sof_err;

    cost_aggr_packer #(
        .NDISP (NDISP),
        .CW    (CW),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .RCW   (RCW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_cost    (s_cost),
        .s_sof     (s_sof),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .cost_aggr (cost_aggr),
        .row_out   (row_out),
        .col_out   (col_out),
        .sof_err   (sof_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            row;
        int            col;
    } pix_t;

    typedef struct {
        logic [CW-1:0] base;
        bit            desc;
        bit            sof0;
        int            exp_row;
        int            exp_col;
        logic [CW-1:0] exp_first;
        logic [CW-1:0] exp_last;
    } vec_t;

    int checks = 0;
    int errors = 0;

    pix_t                     sb [$];
    logic [NDISP-1:0][CW-1:0] mdl_data;
    int                       mdl_d, mdl_row, mdl_col, px_out;
    logic                     exp_sof_err;

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clearModel();
        sb.delete();
        mdl_data    = '0;
        mdl_d       = 0;
        mdl_row     = 0;
        mdl_col     = 0;
        px_out      = 0;
        exp_sof_err = 1'b0;
    endtask

    // Reference model and scoreboard, evaluated mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("m_valid", DW'(m_valid), DW'(sb.size() != 0));
            checkOutput("s_ready", DW'(s_ready), DW'(sb.size() < 2));
            checkOutput("sof_err", DW'(sof_err), DW'(exp_sof_err));
            if (m_valid && sb.size() != 0) begin
                checkOutput("sb_data", cost_aggr, sb[0].data);
                checkOutput("sb_row", DW'(row_out), DW'(sb[0].row));
                checkOutput("sb_col", DW'(col_out), DW'(sb[0].col));
                if (m_ready) begin
                    if (px_out == IMG_W) begin
                        checkOutput("wrap_col_row", DW'(row_out), DW'(1));
                        checkOutput("wrap_col_col", DW'(col_out), DW'(0));
                    end
                    if (px_out == IMG_W * IMG_H) begin
                        checkOutput("wrap_row_row", DW'(row_out), DW'(0));
                        checkOutput("wrap_row_col", DW'(col_out), DW'(0));
                    end
                    void'(sb.pop_front());
                    px_out++;
                end
            end
            if (s_valid && s_ready) begin
                if (s_sof) begin
                    if (mdl_d != 0) exp_sof_err = 1'b1;
                    mdl_d   = 0;
                    mdl_row = 0;
                    mdl_col = 0;
                end
                mdl_data[mdl_d] = s_cost;
                if (mdl_d == NDISP - 1) begin
                    sb.push_back('{data: mdl_data, row: mdl_row, col: mdl_col});
                    mdl_d = 0;
                    if (mdl_col == IMG_W - 1) begin
                        mdl_col = 0;
                        mdl_row = (mdl_row == IMG_H - 1) ? 0 : mdl_row + 1;
                    end else begin
                        mdl_col++;
                    end
                end else begin
                    mdl_d++;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [CW-1:0] cost, input logic sof);
        bit done = 1'b0;
        s_valid = 1'b1;
        s_cost  = cost;
        s_sof   = sof;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (s_ready) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL beat_timeout: got s_ready 0 expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic sendPixel(input logic [CW-1:0] base, input bit desc, input int sof_beat, input bit mr_last);
        for (int d = 0; d < NDISP; d++) begin
            if (mr_last && d == NDISP - 1) m_ready = 1'b1;
            applyStimulus(desc ? base - CW'(d) : base + CW'(d), d == sof_beat);
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
        if (mr_last) m_ready = 1'b0;
    endtask

    task automatic waitValid(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (m_valid) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got m_valid 0 expected 1 within 300 cycles", name);
        end
    endtask

    task automatic checkPixel(input string name, input int exp_row, input int exp_col,
                              input logic [CW-1:0] first, input logic [CW-1:0] last);
        waitValid(name);
        checkOutput({name, "_row"}, DW'(row_out), DW'(exp_row));
        checkOutput({name, "_col"}, DW'(col_out), DW'(exp_col));
        checkOutput({name, "_slot0"}, DW'(cost_aggr[0 +: CW]), DW'(first));
        checkOutput({name, "_slotlast"}, DW'(cost_aggr[(NDISP-1)*CW +: CW]), DW'(last));
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        bit empty = 1'b0;
        for (int i = 0; i < 2000 && !empty; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !m_valid) empty = 1'b1;
        end
        checkOutput({name, "_drained"}, DW'(empty), DW'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        rst     = 1'b1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_cost  = '0;
        m_ready = 1'b0;
        clearModel();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_m_valid", DW'(m_valid), DW'(0));
        checkOutput("rst_s_ready", DW'(s_ready), DW'(0));
        checkOutput("rst_cost_aggr", cost_aggr, DW'(0));
        checkOutput("rst_row", DW'(row_out), DW'(0));
        checkOutput("rst_col", DW'(col_out), DW'(0));
        checkOutput("rst_sof_err", DW'(sof_err), DW'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete within 1 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs [5];
        vecs[0] = '{base: 16'd100,   desc: 1'b0, sof0: 1'b0, exp_row: 0, exp_col: 0, exp_first: 16'd100,   exp_last: 16'd153};
        vecs[1] = '{base: 16'hFFFF,  desc: 1'b1, sof0: 1'b0, exp_row: 0, exp_col: 1, exp_first: 16'hFFFF,  exp_last: 16'hFFCA};
        vecs[2] = '{base: 16'h0000,  desc: 1'b0, sof0: 1'b1, exp_row: 0, exp_col: 0, exp_first: 16'h0000,  exp_last: 16'h0035};
        vecs[3] = '{base: 16'h8000,  desc: 1'b0, sof0: 1'b0, exp_row: 0, exp_col: 1, exp_first: 16'h8000,  exp_last: 16'h8035};
        vecs[4] = '{base: 16'h0F00,  desc: 1'b1, sof0: 1'b0, exp_row: 0, exp_col: 2, exp_first: 16'h0F00,  exp_last: 16'h0ECB};

        rst     = 1'b1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_cost  = '0;
        m_ready = 1'b0;
        clearModel();

        // Single pixels with one-cycle latency check and table expectations.
        resetDut();
        for (int v = 0; v < 5; v++) begin
            sendPixel(vecs[v].base, vecs[v].desc, vecs[v].sof0 ? 0 : -1, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_latency", v), DW'(m_valid), DW'(1));
            checkPixel($sformatf("vec%0d", v), vecs[v].exp_row, vecs[v].exp_col,
                       vecs[v].exp_first, vecs[v].exp_last);
        end

        // Three pixels into a stalled consumer: third pixel must wait for m_ready.
        resetDut();
        fork
            begin
                for (int p = 0; p < 3; p++) sendPixel(CW'(200 + 100 * p), 1'b0, -1, 1'b0);
            end
            begin
                bit full2 = 1'b0;
                for (int i = 0; i < 400 && !full2; i++) begin
                    @(negedge clk);
                    if (sb.size() == 2) full2 = 1'b1;
                end
                @(negedge clk);
                checkOutput("stall_ready", DW'(s_ready), DW'(0));
                checkOutput("stall_col", DW'(col_out), DW'(0));
                repeat (10) @(posedge clk);
                #1;
                m_ready = 1'b1;
            end
        join
        waitDrain("stall");
        m_ready = 1'b0;

        // Completion and handshake on the same edge in state ONE.
        resetDut();
        sendPixel(16'd300, 1'b0, -1, 1'b0);
        sendPixel(16'd400, 1'b0, -1, 1'b1);
        @(negedge clk);
        checkOutput("same_cycle_valid", DW'(m_valid), DW'(1));
        checkOutput("same_cycle_ready", DW'(s_ready), DW'(1));
        checkOutput("same_cycle_col", DW'(col_out), DW'(1));
        checkPixel("same_cycle", 0, 1, 16'd400, 16'd453);

        // Raster wrap: column wrap at IMG_W and row wrap at IMG_W*IMG_H.
        resetDut();
        m_ready = 1'b1;
        for (int p = 0; p < IMG_W * IMG_H + 1; p++) sendPixel(CW'(p * 7), 1'b0, -1, 1'b0);
        waitDrain("raster");
        checkOutput("raster_count", DW'(px_out), DW'(IMG_W * IMG_H + 1));
        m_ready = 1'b0;

        // SOF on beat 20 of a pixel discards the partial pixel and restarts at (0,0).
        resetDut();
        for (int d = 0; d < 20; d++) applyStimulus(CW'(900 + d), 1'b0);
        sendPixel(16'd500, 1'b0, 0, 1'b0);
        @(negedge clk);
        checkOutput("sof_mid_err", DW'(sof_err), DW'(1));
        checkPixel("sof_mid", 0, 0, 16'd500, 16'd553);
        repeat (3) @(negedge clk);
        checkOutput("sof_mid_no_extra", DW'(m_valid), DW'(0));
        @(posedge clk);
        #1;

        // Asynchronous reset mid-pixel while a pixel is being presented.
        sendPixel(16'd600, 1'b0, -1, 1'b0);
        for (int d = 0; d < 10; d++) applyStimulus(CW'(650 + d), 1'b0);
        s_valid = 1'b0;
        checkOutput("arst_pre_valid", DW'(m_valid), DW'(1));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_m_valid", DW'(m_valid), DW'(0));
        checkOutput("arst_s_ready", DW'(s_ready), DW'(0));
        checkOutput("arst_cost_aggr", cost_aggr, DW'(0));
        checkOutput("arst_row", DW'(row_out), DW'(0));
        checkOutput("arst_col", DW'(col_out), DW'(0));
        checkOutput("arst_sof_err", DW'(sof_err), DW'(0));
        clearModel();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        sendPixel(16'd700, 1'b0, -1, 1'b0);
        checkPixel("arst_fresh", 0, 0, 16'd700, 16'd753);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
